ac_sequencer: RTL and testbench
===============================

AC_SEQUENCER -- requirements
Module: ac_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, is the width of the memory word address and of the program counter.
REQ-002 Parameter DATA_BASE, default 8'h80, is the word address added to a 12-bit field to form a data-operand address, truncated to ADDR_W.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse; begins execution at pc = 0 when idle or halted.
REQ-006 mem_req  output  1  read request; held high until the cycle mem_valid is sampled high.
REQ-007 mem_addr  output  ADDR_W  read word address; stable while mem_req is high.
REQ-008 mem_rdata  input  32  read data; sampled only in a cycle with mem_valid high.
REQ-009 mem_valid  input  1  read-complete strobe; ignored while mem_req is low.
REQ-010 opcode  output  4  accumulator opcode: 4'h0 ADD, 4'h2 LOAD, 4'hF NO_OP.
REQ-011 operand  output  32  accumulator operand; valid when opcode != 4'hF.
REQ-012 busy  output  1  high in every state except IDLE and HALT.
REQ-013 halted  output  1  high in HALT.
REQ-014 pc  output  ADDR_W  current program counter.

Function
REQ-015 Instruction word = mem_rdata[15:0]: [15:12] op, [11:0] imm; mem_rdata[31:16] is ignored on fetches.
REQ-016 Op decode:
- 0 ADDI: ADD with operand = zero-extended imm.
- 1 ADDM: ADD with operand = mem[DATA_BASE + imm].
- 2 LDI: LOAD with operand = zero-extended imm.
- 3 LDM: LOAD with operand = mem[DATA_BASE + imm].
- E HALT: enters HALT.
- all other values: NOP, nothing issued.
REQ-017 States are IDLE, FETCH, DECODE, OPER, ISSUE and HALT.
REQ-018 IDLE -> FETCH on start.
REQ-019 FETCH asserts mem_req with mem_addr = pc; on mem_valid, latches the instruction, then -> DECODE.
REQ-020 DECODE:
- ops 1 and 3 -> OPER.
- ops 0 and 2 -> ISSUE.
- HALT -> HALT.
- NOP: pc += 1, -> FETCH.
REQ-021 OPER asserts mem_req with mem_addr = DATA_BASE + imm; on mem_valid, latches the full 32-bit mem_rdata, then -> ISSUE.
REQ-022 ISSUE drives opcode/operand for exactly one cycle, increments pc, then -> FETCH.
REQ-023 In every cycle other than ISSUE, opcode = 4'hF and operand = 0.
REQ-024 The pc increment wraps modulo 2^ADDR_W without a halt or error.
REQ-025 HALT holds pc; start -> FETCH with pc = 0.
REQ-026 start while busy is ignored.
REQ-027 mem_req drops in the cycle after mem_valid is sampled, and at most one request is outstanding.
REQ-028 mem_valid in the same cycle mem_req first rises is accepted, giving a minimum FETCH of 1 cycle.
REQ-029 Minimum latency from the start cycle to the ISSUE cycle is 3 cycles for immediate ops and 4 cycles for memory ops.

Reset
REQ-030 Reset low asynchronously forces the following, at any point including mid-request:
- IDLE state.
- pc = 0, mem_req = 0, mem_addr = 0.
- opcode = 4'hF, operand = 0.
- busy = 0, halted = 0.
REQ-031 After reset, a mem_valid belonging to an aborted request is ignored.
REQ-032 Execution resumes only on a new start.

Verification
REQ-033 Program {16'h2005, 16'h0003, 16'hE000} with zero-wait memory; pulse start:
- one issue of LOAD 5, then one issue of ADD 3.
- then halted = 1 with pc = 2.
REQ-034 Set mem[8'h84] = 32'hDEADBEEF and run program {16'h3004, 16'hE000}:
- mem_addr = 8'h84 during OPER.
- issue of LOAD 32'hDEADBEEF.
REQ-035 Insert 3 wait cycles before each mem_valid:
- mem_req and mem_addr remain stable throughout each wait.
- opcode stays 4'hF until the issue cycle.
- the issue sequence is unchanged.
REQ-036 Fill memory with 16'h7000 (NOP) and run 256 fetches:
- pc wraps 8'hFF -> 8'h00.
- no instruction is issued.
- busy stays 1.
REQ-037 Assert reset low during an outstanding OPER request, then pulse mem_valid:
- all outputs take their reset values immediately.
- no issue occurs.
- after start, fetch restarts at address 0.
REQ-038 Pulse start while busy:
- no effect on pc or state.
- start pulsed in HALT restarts execution from pc = 0.

Source files
------------

// File: rtl/ac_sequencer.sv
// Instruction sequencer for an accumulator: fetches 16-bit words, optionally fetches a
// 32-bit data operand, and issues one ADD/LOAD per instruction to the accumulator.
module ac_sequencer #(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] DATA_BASE = 8'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [3:0]        opcode,
    output logic [31:0]       operand,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_OPER   = 3'd3;
    localparam logic [2:0] ST_ISSUE  = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h2;
    localparam logic [3:0] OP_NONE = 4'hF;

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       instr_reg, instr_next;
    logic [31:0]       operand_reg, operand_next;

    logic [3:0]        instr_op;
    logic [11:0]       instr_imm;
    logic [ADDR_W-1:0] data_addr;

    assign instr_op  = instr_reg[15:12];
    assign instr_imm = instr_reg[11:0];
    // Address arithmetic wraps at ADDR_W bits, so large immediates alias into low memory.
    assign data_addr = DATA_BASE + ADDR_W'(instr_imm);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            instr_reg   <= '0;
            operand_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            operand_reg <= operand_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        operand_next = operand_reg;
        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_valid) begin
                    instr_next = mem_rdata[15:0];
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (instr_op)
                    4'h1, 4'h3: state_next = ST_OPER;
                    4'h0, 4'h2: begin
                        operand_next = {20'd0, instr_imm};
                        state_next   = ST_ISSUE;
                    end
                    4'hE: state_next = ST_HALT;
                    default: begin
                        pc_next    = pc_reg + ADDR_W'(1);
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_OPER: begin
                if (mem_valid) begin
                    operand_next = mem_rdata;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pc_next    = pc_reg + ADDR_W'(1);
                state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        opcode   = OP_NONE;
        operand  = '0;
        case (state_reg)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
            end
            ST_OPER: begin
                mem_req  = 1'b1;
                mem_addr = data_addr;
            end
            ST_ISSUE: begin
                opcode  = instr_op[1] ? OP_LOAD : OP_ADD;
                operand = operand_reg;
            end
            default: ;
        endcase
    end

    assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halted = (state_reg == ST_HALT);
    assign pc     = pc_reg;

endmodule

// File: tb/tb_ac_sequencer.sv
// Randomized bench for ac_sequencer: an instruction-level interpreter predicts the request
// address stream and the issue stream, and a negedge monitor compares the DUT against it.
module tb_ac_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [3:0]  opcode;
    logic [31:0] operand;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;

    ac_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .opcode    (opcode),
        .operand   (operand),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [256];
    logic [35:0] exp_issue[$];
    logic [35:0] got_issue[$];
    logic [7:0]  exp_addr[$];
    logic [7:0]  got_addr[$];
    logic [7:0]  model_pc;
    bit          model_halts;

    int n_checks = 0;
    int n_fail   = 0;

    bit          manual = 1'b0;
    logic        man_valid = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        auto_valid = 1'b0;
    logic [31:0] auto_rdata = '0;
    assign mem_valid = manual ? man_valid : auto_valid;
    assign mem_rdata = manual ? man_rdata : auto_rdata;

    bit   rand_waits = 1'b0;
    bit   noise = 1'b0;
    bit   expect_busy = 1'b0;
    int   waits_fixed = 0;
    int   cur_waits = 0;
    int   wait_cnt = 0;
    bit   prev_req = 1'b0;
    bit   gave_valid = 1'b0;
    logic [7:0] prev_addr = '0;
    int   start_cyc = 0;
    int   first_issue_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h", name, act);
    endtask

    // Interpreter: walks the program one instruction at a time from pc 0.
    task automatic build_model(input int max_fetch);
        logic [7:0]  pcm;
        logic [15:0] ins;
        logic [7:0]  da;
        pcm = 8'd0;
        model_halts = 1'b0;
        for (int f = 0; f < max_fetch; f++) begin
            exp_addr.push_back(pcm);
            ins = mem[pcm][15:0];
            da  = 8'((32'h80 + 32'(ins[11:0])) % 256);
            case (ins[15:12])
                4'h0: exp_issue.push_back({4'h0, 20'd0, ins[11:0]});
                4'h1: begin exp_addr.push_back(da); exp_issue.push_back({4'h0, mem[da]}); end
                4'h2: exp_issue.push_back({4'h2, 20'd0, ins[11:0]});
                4'h3: begin exp_addr.push_back(da); exp_issue.push_back({4'h2, mem[da]}); end
                4'hE: begin
                    model_halts = 1'b1;
                    model_pc = pcm;
                    return;
                end
                default: ;
            endcase
            pcm = 8'((32'(pcm) + 1) % 256);
        end
        model_pc = pcm;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            auto_valid = 1'b0;
            wait_cnt   = 0;
            prev_req   = 1'b0;
            gave_valid = 1'b0;
        end else begin
            if (opcode !== 4'hF) begin
                got_issue.push_back({opcode, operand});
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                if (exp_issue.size() == 0) fail_now("unexpected_issue", {opcode, operand});
                else check("issue", {opcode, operand}, exp_issue.pop_front());
            end else begin
                check("idle_operand", operand, 0);
            end
            check("busy_halted_excl", busy & halted, 0);
            if (expect_busy) check("busy_held", busy, 1);
            if (!manual) begin
                if (gave_valid) check("req_drop", mem_req, 0);
                gave_valid = 1'b0;
                if (mem_req) begin
                    if (prev_req) check("addr_stable", mem_addr, prev_addr);
                    if (wait_cnt >= cur_waits) begin
                        auto_valid = 1'b1;
                        auto_rdata = mem[mem_addr];
                        got_addr.push_back(mem_addr);
                        if (exp_addr.size() == 0) fail_now("unexpected_request", mem_addr);
                        else check("req_addr", mem_addr, exp_addr.pop_front());
                        wait_cnt   = 0;
                        cur_waits  = rand_waits ? int'($urandom_range(0, 3)) : waits_fixed;
                        prev_req   = 1'b0;
                        gave_valid = 1'b1;
                    end else begin
                        auto_valid = 1'b0;
                        wait_cnt++;
                        prev_req  = 1'b1;
                        prev_addr = mem_addr;
                    end
                end else begin
                    if (prev_req) fail_now("req_dropped_early", mem_addr);
                    prev_req   = 1'b0;
                    auto_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    auto_rdata = $urandom;
                end
            end
        end
    end

    task automatic prepare();
        exp_issue.delete();
        exp_addr.delete();
        got_issue.delete();
        got_addr.delete();
        first_issue_cyc = -1;
        wait_cnt   = 0;
        cur_waits  = waits_fixed;
        prev_req   = 1'b0;
        gave_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (halted) return;
        end
        fail_now("halt_timeout", pc);
    endtask

    task automatic check_reset_vals();
        check("rst_pc", pc, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_opcode", opcode, 4'hF);
        check("rst_operand", operand, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
    endtask

    task automatic run_prog(input int budget);
        prepare();
        build_model(300);
        pulse_start();
        wait_halt(budget);
        @(negedge clk);
        #1;
        check("end_halted", halted, 1);
        check("end_busy", busy, 0);
        check("end_pc", pc, model_pc);
        check("issues_left", exp_issue.size(), 0);
        check("fetches_left", exp_addr.size(), 0);
    endtask

    task automatic fill_mem(input logic [15:0] word);
        for (int i = 0; i < 256; i++) mem[i] = {16'($urandom), word};
    endtask

    initial begin
        fill_mem(16'hE000);
        repeat (3) @(negedge clk);
        #1 check_reset_vals();
        @(negedge clk);
        #1 reset = 1'b1;

        // Immediate program, zero-wait memory.
        mem[0] = 32'h0000_2005;
        mem[1] = 32'hFFFF_0003;
        mem[2] = 32'h0000_E000;
        run_prog(200);
        check("t1_latency", first_issue_cyc - start_cyc, 3);
        check("t1_count", got_issue.size(), 2);
        if (got_issue.size() >= 2) begin
            check("t1_issue0", got_issue[0], {4'h2, 32'd5});
            check("t1_issue1", got_issue[1], {4'h0, 32'd3});
        end
        check("t1_pc", pc, 8'd2);

        // Memory operand load, restarted from HALT.
        fill_mem(16'hE000);
        mem[0]     = 32'hABCD_3004;
        mem[1]     = 32'h1234_E000;
        mem[8'h84] = 32'hDEAD_BEEF;
        run_prog(200);
        check("t2_latency", first_issue_cyc - start_cyc, 4);
        check("t2_nreq", got_addr.size(), 3);
        if (got_addr.size() >= 2) check("t2_oper_addr", got_addr[1], 8'h84);
        if (got_issue.size() >= 1) check("t2_issue", got_issue[0], {4'h2, 32'hDEAD_BEEF});

        // Three wait cycles before every mem_valid.
        waits_fixed = 3;
        mem[0] = 32'h0000_2005;
        mem[1] = 32'h0000_1004;
        mem[2] = 32'h0000_0003;
        mem[3] = 32'h0000_E000;
        run_prog(400);
        check("t3_latency", first_issue_cyc - start_cyc, 6);
        check("t3_count", got_issue.size(), 3);
        if (got_issue.size() >= 3) begin
            check("t3_issue0", got_issue[0], {4'h2, 32'd5});
            check("t3_issue1", got_issue[1], {4'h0, 32'hDEAD_BEEF});
            check("t3_issue2", got_issue[2], {4'h0, 32'd3});
        end

        // Random programs with random waits, bus noise, and a start pulse while busy.
        waits_fixed = 0;
        rand_waits  = 1'b1;
        noise       = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int op;
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            for (int i = 0; i < 40; i++) begin
                op = int'($urandom_range(0, 15));
                if (op == 14 && $urandom_range(0, 3) != 0) op = 7;
                mem[i][15:12] = 4'(op);
            end
            mem[40] = 32'h0000_E000;
            prepare();
            build_model(300);
            pulse_start();
            repeat ($urandom_range(3, 20)) @(negedge clk);
            #1;
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                #1 start = 1'b0;
            end
            wait_halt(3000);
            @(negedge clk);
            #1;
            check("rnd_halted", halted, 1);
            check("rnd_pc", pc, model_pc);
            check("rnd_issues_left", exp_issue.size(), 0);
            check("rnd_fetches_left", exp_addr.size(), 0);
        end
        rand_waits = 1'b0;
        noise      = 1'b0;

        // All-NOP memory: pc must wrap through 8'hFF back to 0 with no issue.
        fill_mem(16'h7000);
        prepare();
        build_model(257);
        pulse_start();
        expect_busy = 1'b1;
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 2000 && !done; i++) begin
                @(posedge clk);
                if (got_addr.size() >= 257) done = 1'b1;
            end
            if (!done) fail_now("nop_timeout", got_addr.size());
        end
        #1;
        expect_busy = 1'b0;
        check("nop_wrap_pc", pc, 8'h00);
        check("nop_nfetch", got_addr.size(), 257);
        if (got_addr.size() >= 257) begin
            check("nop_addr_ff", got_addr[255], 8'hFF);
            check("nop_addr_00", got_addr[256], 8'h00);
        end
        check("nop_issues", got_issue.size(), 0);
        reset = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        #1 reset = 1'b1;

        // Reset during an outstanding OPER request.
        manual = 1'b1;
        prepare();
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (mem_req) seen = 1'b1;
                else begin @(negedge clk); #1; end
            end
            if (!seen) fail_now("t6_fetch_timeout", 0);
        end
        check("t6_fetch_addr", mem_addr, 8'h00);
        man_rdata = 32'h0000_3004;
        man_valid = 1'b1;
        @(negedge clk);
        #1 man_valid = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                #1;
                if (mem_req) seen = 1'b1;
            end
            if (!seen) fail_now("t6_oper_timeout", 0);
        end
        check("t6_oper_addr", mem_addr, 8'h84);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        man_rdata = 32'hDEAD_BEEF;
        man_valid = 1'b1;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 man_valid = 1'b1;
        @(negedge clk);
        #1 man_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_req", mem_req, 0);
        check("t6_no_busy", busy, 0);
        check("t6_pc", pc, 0);
        check("t6_no_issue", got_issue.size(), 0);
        manual = 1'b0;

        fill_mem(16'hE000);
        mem[0] = 32'h0000_0007;
        run_prog(200);
        if (got_addr.size() >= 1) check("t6_restart_addr", got_addr[0], 8'h00);
        if (got_issue.size() >= 1) check("t6_restart_issue", got_issue[0], {4'h0, 32'd7});
        check("t6_restart_count", got_issue.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
